// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - ISA constants, bypass selects and Tuse/Tnew timing for hazard_ctrl
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] SEL_REG   = 3'd0;
  localparam logic [2:0] SEL_W     = 3'd1;
  localparam logic [2:0] SEL_PC8_M = 3'd2;
  localparam logic [2:0] SEL_ALU_M = 3'd3;
  localparam logic [2:0] SEL_PC8_E = 3'd4;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_JAL  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LW   = 2'd2;

  localparam logic [4:0] REG_RA    = 5'd31;

  // Per-stage shadow of the instruction: sources stay with it so E/M selects are stage-local.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
    logic       is_jal;
  } stage_t;

  localparam stage_t STAGE_NOP = '0;

  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_instr_decode.sv
// rtl/hazard_ctrl_instr_decode.sv - maps one instruction to its sources, destination and timing
module instr_decode
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dst,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic [1:0]  tnew,
  output logic        is_jal
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_shamt;

  assign op           = instr[31:26];
  assign fn           = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  // Unused source fields are reported as $0 with Tuse=3 so they can never hit.
  always_comb begin
    rs      = 5'd0;
    rt      = 5'd0;
    dst     = 5'd0;
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    tnew    = TNEW_JAL;
    is_jal  = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_ADDU || fn == FN_SUBU) begin
          rs      = instr[25:21];
          rt      = instr[20:16];
          dst     = instr[15:11];
          tuse_rs = TUSE_1;
          tuse_rt = TUSE_1;
          tnew    = TNEW_ALU;
        end else if (fn == FN_JR) begin
          rs      = instr[25:21];
          tuse_rs = TUSE_0;
        end
      end
      OP_ORI: begin
        rs      = instr[25:21];
        tuse_rs = TUSE_1;
        dst     = instr[20:16];
        tnew    = TNEW_ALU;
      end
      OP_LUI: begin
        dst  = instr[20:16];
        tnew = TNEW_ALU;
      end
      OP_LW: begin
        rs      = instr[25:21];
        tuse_rs = TUSE_1;
        dst     = instr[20:16];
        tnew    = TNEW_LW;
      end
      OP_SW: begin
        rs      = instr[25:21];
        rt      = instr[20:16];
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_2;
      end
      OP_BEQ: begin
        rs      = instr[25:21];
        rt      = instr[20:16];
        tuse_rs = TUSE_0;
        tuse_rt = TUSE_0;
      end
      OP_JAL: begin
        dst    = REG_RA;
        tnew   = TNEW_JAL;
        is_jal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall and bypass-select generation for a 5-stage pipeline
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  output logic        stall,
  output logic [2:0]  rsd_sel,
  output logic [2:0]  rtd_sel,
  output logic [2:0]  rse_sel,
  output logic [2:0]  rte_sel,
  output logic [2:0]  rtm_sel,
  output logic [4:0]  a3_w
);

  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_is_jal;

  stage_t e_q, m_q, w_q;
  stage_t e_n, m_n;
  logic   stall_rs, stall_rt;
  logic   unused_fields;

  instr_decode u_decode (
    .instr   (ir_d),
    .rs      (d_rs),
    .rt      (d_rt),
    .dst     (d_dst),
    .tuse_rs (d_tuse_rs),
    .tuse_rt (d_tuse_rt),
    .tnew    (d_tnew),
    .is_jal  (d_is_jal)
  );

  assign unused_fields = ^{m_q.rs, w_q.rs, w_q.rt, w_q.tnew, w_q.is_jal};

  always_comb begin
    e_n = stall ? STAGE_NOP : '{rs: d_rs, rt: d_rt, dst: d_dst, tnew: d_tnew, is_jal: d_is_jal};
    m_n = e_q;
    m_n.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= STAGE_NOP;
      m_q <= STAGE_NOP;
      w_q <= STAGE_NOP;
    end else begin
      e_q <= e_n;
      m_q <= m_n;
      w_q <= m_q;
    end
  end

  function automatic logic [2:0] sel_d(input logic [4:0] src, input stage_t e,
                                       input stage_t m, input stage_t w);
    if (reg_hit(src, e.dst) && e.tnew == 2'd0)      return SEL_PC8_E;
    else if (reg_hit(src, m.dst) && m.tnew == 2'd0) return m.is_jal ? SEL_PC8_M : SEL_ALU_M;
    else if (reg_hit(src, w.dst))                   return SEL_W;
    else                                            return SEL_REG;
  endfunction

  function automatic logic [2:0] sel_e(input logic [4:0] src, input stage_t m, input stage_t w);
    if (reg_hit(src, m.dst) && m.tnew == 2'd0) return m.is_jal ? SEL_PC8_M : SEL_ALU_M;
    else if (reg_hit(src, w.dst))              return SEL_W;
    else                                       return SEL_REG;
  endfunction

  // Gated by reset so an in-flight stall drops in the same cycle reset asserts.
  always_comb begin
    stall_rs = (reg_hit(d_rs, e_q.dst) && e_q.tnew > d_tuse_rs) ||
               (reg_hit(d_rs, m_q.dst) && m_q.tnew > d_tuse_rs);
    stall_rt = (reg_hit(d_rt, e_q.dst) && e_q.tnew > d_tuse_rt) ||
               (reg_hit(d_rt, m_q.dst) && m_q.tnew > d_tuse_rt);
    stall    = ~reset & (stall_rs | stall_rt);
  end

  assign rsd_sel = sel_d(d_rs, e_q, m_q, w_q);
  assign rtd_sel = sel_d(d_rt, e_q, m_q, w_q);
  assign rse_sel = sel_e(e_q.rs, m_q, w_q);
  assign rte_sel = sel_e(e_q.rt, m_q, w_q);
  assign rtm_sel = reg_hit(m_q.rt, w_q.dst) ? SEL_W : SEL_REG;
  assign a3_w    = w_q.dst;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_d;
  logic        stall;
  logic [2:0]  rsd_sel, rtd_sel, rse_sel, rte_sel, rtm_sel;
  logic [4:0]  a3_w;

  int checks_total  = 0;
  int checks_passed = 0;

  hazard_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .ir_d    (ir_d),
    .stall   (stall),
    .rsd_sel (rsd_sel),
    .rtd_sel (rtd_sel),
    .rse_sel (rse_sel),
    .rte_sel (rte_sel),
    .rtm_sel (rtm_sel),
    .a3_w    (a3_w)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt);
    return {op, rs, rt, 16'd0};
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks_total++;
    if (got == exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one cycle: new D instruction driven mid-low-phase, outputs settle before checks.
  task automatic set_d(input logic [31:0] instr);
    @(negedge clk);
    ir_d = instr;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ir_d  = i_op(6'h04, 5'd1, 5'd2);
    #12;
    check("rst_stall", stall, 0);
    check("rst_rsd", rsd_sel, 0);
    check("rst_rse", rse_sel, 0);
    check("rst_rtm", rtm_sel, 0);
    check("rst_a3w", a3_w, 0);
    @(negedge clk);
    reset = 1'b0;
    set_d(NOP);
    flush();

    // lw $1 ; addu $2,$1,$1
    set_d(i_op(6'h23, 5'd0, 5'd1));
    check("lw_no_stall", stall, 0);
    set_d(r_op(5'd1, 5'd1, 5'd2, 6'h21));
    check("lwuse_stall", stall, 1);
    set_d(r_op(5'd1, 5'd1, 5'd2, 6'h21));
    check("lwuse_release", stall, 0);
    set_d(NOP);
    check("lwuse_rse", rse_sel, 1);
    check("lwuse_rte", rte_sel, 1);
    check("lwuse_a3w", a3_w, 1);
    flush();

    // lw $1 ; beq $1,$0
    set_d(i_op(6'h23, 5'd0, 5'd1));
    set_d(i_op(6'h04, 5'd1, 5'd0));
    check("beq_stall1", stall, 1);
    set_d(i_op(6'h04, 5'd1, 5'd0));
    check("beq_stall2", stall, 1);
    set_d(i_op(6'h04, 5'd1, 5'd0));
    check("beq_release", stall, 0);
    check("beq_rsd", rsd_sel, 1);
    check("beq_rtd", rtd_sel, 0);
    flush();

    // addu $3 ; jr $3
    set_d(r_op(5'd1, 5'd2, 5'd3, 6'h21));
    set_d(r_op(5'd3, 5'd0, 5'd0, 6'h08));
    check("jr_stall", stall, 1);
    set_d(r_op(5'd3, 5'd0, 5'd0, 6'h08));
    check("jr_release", stall, 0);
    check("jr_rsd_alu", rsd_sel, 3);
    flush();

    // jal ; jr $31 ; jr $31
    set_d({6'h03, 26'd0});
    set_d(r_op(5'd31, 5'd0, 5'd0, 6'h08));
    check("jal_stall", stall, 0);
    check("jal_rsd_e", rsd_sel, 4);
    set_d(r_op(5'd31, 5'd0, 5'd0, 6'h08));
    check("jal_rsd_m", rsd_sel, 2);
    set_d(NOP);
    check("jal_a3w", a3_w, 31);
    flush();

    // lw $4 ; sw $4,0($0)
    set_d(i_op(6'h23, 5'd0, 5'd4));
    set_d(i_op(6'h2b, 5'd0, 5'd4));
    check("sw_stall", stall, 0);
    set_d(NOP);
    check("sw_rte", rte_sel, 0);
    set_d(NOP);
    check("sw_rtm", rtm_sel, 1);
    flush();

    // addu $0,... ; addu $5,$0,$0
    set_d(r_op(5'd1, 5'd2, 5'd0, 6'h21));
    set_d(r_op(5'd0, 5'd0, 5'd5, 6'h21));
    check("zero_stall", stall, 0);
    check("zero_rsd", rsd_sel, 0);
    check("zero_rtd", rtd_sel, 0);
    set_d(NOP);
    check("zero_rse", rse_sel, 0);
    check("zero_rte", rte_sel, 0);
    flush();

    // lui / subu / ori producers feeding branch-class consumers
    set_d(i_op(6'h0f, 5'd0, 5'd6));
    set_d(r_op(5'd6, 5'd0, 5'd0, 6'h08));
    check("lui_stall", stall, 1);
    flush();
    set_d(r_op(5'd1, 5'd2, 5'd8, 6'h23));
    set_d(i_op(6'h04, 5'd0, 5'd8));
    check("subu_stall", stall, 1);
    flush();
    set_d(i_op(6'h0d, 5'd1, 5'd9));
    set_d(NOP);
    set_d(r_op(5'd9, 5'd9, 5'd10, 6'h21));
    check("ori_stall", stall, 0);
    check("ori_rsd", rsd_sel, 3);
    check("ori_rtd", rtd_sel, 3);
    flush();

    // reset asserted mid-stall
    set_d(r_op(5'd0, 5'd0, 5'd7, 6'h21));
    set_d(i_op(6'h23, 5'd0, 5'd1));
    set_d(i_op(6'h04, 5'd1, 5'd0));
    check("rs_stall_a", stall, 1);
    set_d(i_op(6'h04, 5'd1, 5'd0));
    check("rs_stall_b", stall, 1);
    check("rs_a3w_pre", a3_w, 7);
    reset = 1'b1;
    #1;
    check("rs_stall_drop", stall, 0);
    check("rs_a3w_clr", a3_w, 0);
    check("rs_rsd_clr", rsd_sel, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_beq_stall", stall, 0);
    set_d(NOP);
    check("post_nop_stall", stall, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  task automatic flush();
    repeat (4) set_d(NOP);
  endtask

endmodule
